// File: rtl/dynamic_branch_predictor.sv
// ---------------------------------------------------------------------------
// dynamic_branch_predictor
//
// Purpose:
//   Dynamic branch predictor. It combines a 2-bit saturating-counter branch
//   history table (BHT) with a tagged branch target buffer (BTB).
//   - Fetch side: a zero-latency combinational lookup on PC_f steers the
//     next PC.
//   - Execute side: the resolved branch updates the tables on the clock edge
//     and produces the mispredict/redirect pair for the flush logic.
//
// Optional feature (macro GSHARE_BRANCH_PREDICTOR_EN):
//   - When defined, a global history register (GHR) of INDEX_BITS bits is
//     XORed into the BHT index.
//   - When undefined, the BHT is indexed by PC alone and no GHR exists.
//   - The BTB is always indexed by PC.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   PC_f              fetch PC
//   predict_taken_f   predicted direction for PC_f
//   predict_target_f  predicted next PC
//   pred_idx_f        BHT index used by this lookup
//   Branch_e ..       resolved branch information from execute, together
//   pred_idx_e        with the prediction carried down the pipeline
//   mispredict        flush F/D and redirect this cycle
//   correct_PC        redirect address
// ---------------------------------------------------------------------------
module dynamic_branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC_f,
  output logic                  predict_taken_f,
  output logic [DATA_WIDTH-1:0] predict_target_f,
  output logic [INDEX_BITS-1:0] pred_idx_f,
  input  logic                  Branch_e,
  input  logic [DATA_WIDTH-1:0] PC_e,
  input  logic [DATA_WIDTH-1:0] PCPlus4_e,
  input  logic                  taken_e,
  input  logic [DATA_WIDTH-1:0] target_e,
  input  logic                  pred_taken_e,
  input  logic [DATA_WIDTH-1:0] pred_target_e,
  input  logic [INDEX_BITS-1:0] pred_idx_e,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] correct_PC
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Saturating increment of a 2-bit counter
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b11;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  // Saturating decrement of a 2-bit counter
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    logic [1:0] r;
    case (c)
      2'b00:   r = 2'b00;
      2'b01:   r = 2'b00;
      2'b10:   r = 2'b01;
      2'b11:   r = 2'b10;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  logic                  valid_q [ENTRIES];
  logic                  valid_d [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q   [ENTRIES];
  logic [TAG_BITS-1:0]   tag_d   [ENTRIES];
  logic [DATA_WIDTH-1:0] tgt_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] tgt_d   [ENTRIES];
  logic [1:0]            bht_q   [ENTRIES];
  logic [1:0]            bht_d   [ENTRIES];
`ifdef GSHARE_BRANCH_PREDICTOR_EN
  logic [INDEX_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] ghr_d;
`endif

  // Fetch-side lookup signals
  logic [INDEX_BITS-1:0] idx_f_s;
  logic [TAG_BITS-1:0]   tag_f_s;
  logic                  hit_f_s;
  logic [DATA_WIDTH-1:0] pc_plus4_f_s;

  // Execute-side update signals
  logic [INDEX_BITS-1:0] idx_e_s;
  logic [TAG_BITS-1:0]   tag_e_s;
  logic                  hit_e_s;

  // PC bits [1:0] and the bits above the tag never take part in indexing
  logic unused_s;
  assign unused_s = ^{PC_f, PC_e};

  assign idx_f_s      = PC_f[INDEX_BITS+1:2];
  assign tag_f_s      = PC_f[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign hit_f_s      = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
  assign pc_plus4_f_s = PC_f + DATA_WIDTH'(4);

  assign idx_e_s = PC_e[INDEX_BITS+1:2];
  assign tag_e_s = PC_e[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign hit_e_s = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);

`ifdef GSHARE_BRANCH_PREDICTOR_EN
  assign pred_idx_f = idx_f_s ^ ghr_q;
`else
  assign pred_idx_f = idx_f_s;
`endif

  // Fetch prediction; a reset in progress forces the fall-through path
  always_comb begin
    predict_taken_f  = 1'b0;
    predict_target_f = pc_plus4_f_s;
    if (!rst && hit_f_s && bht_q[pred_idx_f][1]) begin
      predict_taken_f  = 1'b1;
      predict_target_f = tgt_q[idx_f_s];
    end else begin
      predict_taken_f  = 1'b0;
      predict_target_f = pc_plus4_f_s;
    end
  end

  // Execute-stage resolution: a predicted-taken non-branch is an alias hit
  always_comb begin
    mispredict = 1'b0;
    correct_PC = PCPlus4_e;
    if (rst) begin
      mispredict = 1'b0;
    end else if (Branch_e) begin
      mispredict = (taken_e != pred_taken_e) ||
                   (taken_e && (target_e != pred_target_e));
    end else begin
      mispredict = pred_taken_e;
    end
    if (Branch_e && taken_e) begin
      correct_PC = target_e;
    end else begin
      correct_PC = PCPlus4_e;
    end
  end

  // Next-state of the BHT/BTB (and GHR) from the resolved branch
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    bht_d   = bht_q;
`ifdef GSHARE_BRANCH_PREDICTOR_EN
    ghr_d   = ghr_q;
`endif
    if (Branch_e) begin
      if (taken_e) begin
        valid_d[idx_e_s] = 1'b1;
        tag_d[idx_e_s]   = tag_e_s;
        tgt_d[idx_e_s]   = target_e;
        // A freshly allocated entry starts weakly taken
        if (!hit_e_s) begin
          bht_d[pred_idx_e] = 2'b10;
        end else begin
          bht_d[pred_idx_e] = sat_inc(bht_q[pred_idx_e]);
        end
      end else begin
        bht_d[pred_idx_e] = sat_dec(bht_q[pred_idx_e]);
      end
`ifdef GSHARE_BRANCH_PREDICTOR_EN
      ghr_d = {ghr_q[INDEX_BITS-2:0], taken_e};
`endif
    end else if (pred_taken_e) begin
      // Drop the BTB entry that wrongly matched a non-branch
      valid_d[idx_e_s] = 1'b0;
    end else begin
      valid_d[idx_e_s] = valid_q[idx_e_s];
    end
  end

  // State registers; reset clears everything in a single cycle and wins over an update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        bht_q[i]   <= 2'b01;
      end
`ifdef GSHARE_BRANCH_PREDICTOR_EN
      ghr_q <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      bht_q   <= bht_d;
`ifdef GSHARE_BRANCH_PREDICTOR_EN
      ghr_q   <= ghr_d;
`endif
    end
  end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Self-checking bench for dynamic_branch_predictor.
//
// An abstract table model (integer counters, plain arrays) predicts every
// output. The model is compared with the DUT on every falling edge. Directed
// steps additionally pin literal expectations.
module tb_dynamic_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_f;
  logic        predict_taken_f;
  logic [31:0] predict_target_f;
  logic [5:0]  pred_idx_f;
  logic        Branch_e;
  logic [31:0] PC_e;
  logic [31:0] PCPlus4_e;
  logic        taken_e;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic [5:0]  pred_idx_e;
  logic        mispredict;
  logic [31:0] correct_PC;

  dynamic_branch_predictor #(.DATA_WIDTH(32), .INDEX_BITS(6), .TAG_BITS(8)) dut (
    .clk(clk), .rst(rst), .PC_f(PC_f),
    .predict_taken_f(predict_taken_f), .predict_target_f(predict_target_f),
    .pred_idx_f(pred_idx_f), .Branch_e(Branch_e), .PC_e(PC_e),
    .PCPlus4_e(PCPlus4_e), .taken_e(taken_e), .target_e(target_e),
    .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
    .pred_idx_e(pred_idx_e), .mispredict(mispredict), .correct_PC(correct_PC)
  );

  always #5 clk = ~clk;

  // Abstract model state
  bit          mv  [64];
  int          mt  [64];
  logic [31:0] mtg [64];
  int          mc  [64];
  int          mghr = 0;

  int errors = 0;
  int checks = 0;

  // Literal pins: bit0 taken, bit1 target, bit2 mispredict, bit3 correct_PC
  logic [3:0]  pin_mask = 4'd0;
  logic        pin_tk;
  logic [31:0] pin_tg;
  logic        pin_mis;
  logic [31:0] pin_cpc;
  string       pin_name = "";

  function automatic void mlook(input logic [31:0] pc, output bit tk,
                                output logic [31:0] tg, output int pi);
    int i;
    int t;
    i  = int'((pc >> 2) & 32'd63);
    t  = int'((pc >> 8) & 32'd255);
    pi = i ^ mghr;
    tk = mv[i] && (mt[i] == t) && (mc[pi] >= 2);
    tg = tk ? mtg[i] : pc + 32'd4;
  endfunction

  // Model update on the clock edge
  always @(posedge clk) begin
    int ei;
    int et;
    int pi;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        mv[i] = 1'b0;
        mc[i] = 1;
      end
      mghr = 0;
    end else if (Branch_e) begin
      ei = int'((PC_e >> 2) & 32'd63);
      et = int'((PC_e >> 8) & 32'd255);
      pi = int'(pred_idx_e);
      if (taken_e) begin
        if (!(mv[ei] && mt[ei] == et)) mc[pi] = 2;
        else if (mc[pi] < 3) mc[pi] = mc[pi] + 1;
        mv[ei]  = 1'b1;
        mt[ei]  = et;
        mtg[ei] = target_e;
      end else if (mc[pi] > 0) begin
        mc[pi] = mc[pi] - 1;
      end
`ifdef GSHARE_BRANCH_PREDICTOR_EN
      mghr = ((mghr << 1) | (taken_e ? 1 : 0)) & 63;
`endif
    end else if (pred_taken_e) begin
      ei = int'((PC_e >> 2) & 32'd63);
      mv[ei] = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model comparison plus any literal pins
  always @(negedge clk) begin
    bit          etk;
    logic [31:0] etg;
    int          epi;
    bit          emis;
    logic [31:0] ecpc;
    mlook(PC_f, etk, etg, epi);
    if (rst) begin
      etk = 1'b0;
      etg = PC_f + 32'd4;
    end
    if (rst) emis = 1'b0;
    else if (Branch_e) emis = (taken_e != pred_taken_e) || (taken_e && target_e != pred_target_e);
    else emis = pred_taken_e;
    ecpc = (Branch_e && taken_e) ? target_e : PCPlus4_e;
    check("model_taken", {31'd0, predict_taken_f}, {31'd0, etk});
    check("model_target", predict_target_f, etg);
    check("model_idx", {26'd0, pred_idx_f}, 32'(epi & 63));
    check("model_mispredict", {31'd0, mispredict}, {31'd0, emis});
    if (emis) check("model_correct_PC", correct_PC, ecpc);
    if (pin_mask[0]) check({pin_name, "/taken"}, {31'd0, predict_taken_f}, {31'd0, pin_tk});
    if (pin_mask[1]) check({pin_name, "/target"}, predict_target_f, pin_tg);
    if (pin_mask[2]) check({pin_name, "/mispredict"}, {31'd0, mispredict}, {31'd0, pin_mis});
    if (pin_mask[3]) check({pin_name, "/correct_PC"}, correct_PC, pin_cpc);
  end

  task automatic drv(input bit br, input logic [31:0] pce, input bit tk, input logic [31:0] tg,
                     input bit pt, input logic [31:0] ptg);
    Branch_e      = br;
    PC_e          = pce;
    PCPlus4_e     = pce + 32'd4;
    taken_e       = tk;
    target_e      = tg;
    pred_taken_e  = pt;
    pred_target_e = ptg;
    pred_idx_e    = 6'((int'((pce >> 2) & 32'd63)) ^ mghr);
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic pin(input string nm, input logic [3:0] m, input bit tk, input logic [31:0] tg,
                     input bit mis, input logic [31:0] cpc);
    pin_name = nm;
    pin_mask = m;
    pin_tk   = tk;
    pin_tg   = tg;
    pin_mis  = mis;
    pin_cpc  = cpc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pin_mask = 4'd0;
  endtask

  initial begin
    bit          ptk;
    logic [31:0] ptg;
    int          ppi;
    logic [31:0] pcs [5];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200;
    pcs[3] = 32'h1100; pcs[4] = 32'h3c0;

    rst  = 1'b1;
    PC_f = 32'h100;
    idle();
    step();
    step();
    rst = 1'b0;

`ifndef GSHARE_BRANCH_PREDICTOR_EN
    pin("reset_lookup", 4'b0111, 1'b0, 32'h104, 1'b0, 32'h0);
    step();
    drv(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    pin("cold_taken", 4'b1100, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    idle();
    pin("after_alloc", 4'b0011, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      pin("sat_taken", 4'b0101, 1'b1, 32'h0, 1'b0, 32'h0);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      // counter seen by the lookup: 11, 10, 01
      pin("sat_not_taken", 4'b1101, (k < 2), 32'h0, 1'b1, 32'h104);
      step();
    end
    drv(1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    pin("wrong_target", 4'b1111, 1'b0, 32'h104, 1'b1, 32'h90);
    step();
    drv(1'b1, 32'h100, 1'b1, 32'h90, 1'b0, 32'h104);
    pin("retrain", 4'b1100, 1'b0, 32'h0, 1'b1, 32'h90);
    step();
    idle();
    pin("new_target", 4'b0011, 1'b1, 32'h90, 1'b0, 32'h0);
    step();
    drv(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    pin("alloc_0x200", 4'b1111, 1'b1, 32'h90, 1'b1, 32'h300);
    step();
    idle();
    pin("tag_mismatch", 4'b0011, 1'b0, 32'h104, 1'b0, 32'h0);
    step();
    PC_f = 32'h200;
    drv(1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h300);
    pin("alias", 4'b1111, 1'b1, 32'h300, 1'b1, 32'h204);
    step();
    idle();
    pin("alias_cleared", 4'b0011, 1'b0, 32'h204, 1'b0, 32'h0);
    step();
    PC_f = 32'h100;
    drv(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    pin("same_idx_alloc", 4'b1111, 1'b0, 32'h104, 1'b1, 32'h80);
    step();
    drv(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    pin("same_idx_old_data", 4'b1111, 1'b1, 32'h80, 1'b1, 32'h104);
    step();
    drv(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    pin("same_idx_weak", 4'b0011, 1'b0, 32'h104, 1'b0, 32'h0);
    step();
    rst = 1'b1;
    drv(1'b1, 32'h340, 1'b1, 32'h500, 1'b1, 32'h80);
    pin("in_reset", 4'b0111, 1'b0, 32'h104, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    idle();
    pin("post_reset_0x100", 4'b0011, 1'b0, 32'h104, 1'b0, 32'h0);
    step();
    PC_f = 32'h340;
    pin("post_reset_0x340", 4'b0011, 1'b0, 32'h344, 1'b0, 32'h0);
    step();
    PC_f = 32'hFFFF_FFFC;
    drv(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h80);
    pin("wrap", 4'b1110, 1'b0, 32'h0, 1'b1, 32'h0);
    step();
`else
    for (int it = 0; it < 24; it++) begin
      mlook(32'h100, ptk, ptg, ppi);
      PC_f = 32'h100;
      drv(1'b1, 32'h100, (it % 2 == 0), 32'h80, ptk, ptg);
      if (it >= 14) pin("gshare_trained", 4'b0100, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
    end
`endif

    // Mixed traffic over a few colliding PCs, compared against the model only
    for (int n = 0; n < 150; n++) begin
      logic [31:0] pe;
      pe = pcs[$urandom_range(4, 0)];
      mlook(pe, ptk, ptg, ppi);
      PC_f = pcs[$urandom_range(4, 0)];
      drv($urandom_range(3, 0) != 0, pe, $urandom_range(1, 0) == 1,
          ($urandom_range(1, 0) == 1) ? 32'h80 : 32'h90, ptk, ptg);
      step();
    end

    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
